// File: rtl/cva6_rvfi_tracker.sv
// cva6_rvfi_tracker: RVFI trace collector. Captures fetch/dispatch/LSU data per
// scoreboard entry, forms ordered retirement records at commit and drains them
// through a retire FIFO to a valid/ready consumer.
// Optional feature macro: RVFI_TRACK_PADDR_EN (per-entry physical address storage).
module cva6_rvfi_tracker #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned NrSbEntries   = 8,
  parameter int unsigned NrLsuPorts    = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned VLEN          = 64,
  parameter int unsigned PLEN          = 56,
  parameter int unsigned FifoDepth     = 4,
  localparam int unsigned IdW          = $clog2(NrSbEntries),
  localparam int unsigned BeW          = XLEN / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  input  logic [31:0]                   fetch_instr_i,
  input  logic                          fetch_compressed_i,
  input  logic                          issue_ack_i,
  input  logic                          dispatch_valid_i,
  input  logic                          dispatch_ack_i,
  input  logic                          flush_unissued_i,
  input  logic [IdW-1:0]                issue_ptr_i,
  input  logic [XLEN-1:0]               rs1_rdata_i,
  input  logic [XLEN-1:0]               rs2_rdata_i,
  input  logic [NrLsuPorts-1:0]         lsu_valid_i,
  input  logic [NrLsuPorts-1:0]         lsu_is_store_i,
  input  logic [NrLsuPorts*IdW-1:0]     lsu_trans_id_i,
  input  logic [NrLsuPorts*VLEN-1:0]    lsu_vaddr_i,
  input  logic [NrLsuPorts*BeW-1:0]     lsu_be_i,
  input  logic [NrLsuPorts*XLEN-1:0]    lsu_wdata_i,
  input  logic [NrLsuPorts*PLEN-1:0]    lsu_paddr_i,
  input  logic [NrCommitPorts-1:0]      commit_valid_i,
  input  logic [NrCommitPorts*IdW-1:0]  commit_ptr_i,
  input  logic [NrCommitPorts*XLEN-1:0] commit_pc_i,
  input  logic [NrCommitPorts*XLEN-1:0] commit_rd_wdata_i,
  input  logic [NrCommitPorts-1:0]      commit_trap_i,
  input  logic [XLEN-1:0]               commit_cause_i,
  output logic                          rec_valid_o,
  input  logic                          rec_ready_i,
  output logic [63:0]                   rec_order_o,
  output logic [31:0]                   rec_insn_o,
  output logic [XLEN-1:0]               rec_pc_o,
  output logic                          rec_trap_o,
  output logic [XLEN-1:0]               rec_cause_o,
  output logic [XLEN-1:0]               rec_rs1_rdata_o,
  output logic [XLEN-1:0]               rec_rs2_rdata_o,
  output logic [XLEN-1:0]               rec_rd_wdata_o,
  output logic [VLEN-1:0]               rec_mem_addr_o,
  output logic [PLEN-1:0]               rec_mem_paddr_o,
  output logic [BeW-1:0]                rec_mem_rmask_o,
  output logic [BeW-1:0]                rec_mem_wmask_o,
  output logic [XLEN-1:0]               rec_mem_wdata_o,
  output logic                          overflow_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PopW = $clog2(NrCommitPorts + 1);

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic            trap;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rd;
    logic [VLEN-1:0] addr;
    logic [PLEN-1:0] paddr;
    logic [BeW-1:0]  rmask;
    logic [BeW-1:0]  wmask;
    logic [XLEN-1:0] wdata;
  } rec_t;

  // Pointer advance modulo FifoDepth; offsets never exceed the depth.
  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= FifoDepth) s = s - FifoDepth;
    return PtrW'(s);
  endfunction

  // ---------------- fetch slot ----------------
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_instr_q, slot_instr_d;

  // Slot load/clear; flush is applied last so it overrides a same-cycle load.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    if (issue_ack_i) slot_valid_d = 1'b0;
    if ((!slot_valid_q || issue_ack_i) && fetch_valid_i) begin
      slot_valid_d = 1'b1;
      slot_instr_d = fetch_compressed_i ? {16'h0000, fetch_instr_i[15:0]} : fetch_instr_i;
    end
    if (flush_i) slot_valid_d = 1'b0;
  end

  // Fetch slot register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= 1'b0;
      slot_instr_q <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
    end
  end

  // ---------------- per-entry metadata ----------------
  logic [31:0]     meta_insn_q  [NrSbEntries];
  logic [XLEN-1:0] meta_rs1_q   [NrSbEntries];
  logic [XLEN-1:0] meta_rs2_q   [NrSbEntries];
  logic [VLEN-1:0] meta_addr_q  [NrSbEntries];
  logic [BeW-1:0]  meta_rmask_q [NrSbEntries];
  logic [BeW-1:0]  meta_wmask_q [NrSbEntries];
  logic [XLEN-1:0] meta_wdata_q [NrSbEntries];
`ifdef RVFI_TRACK_PADDR_EN
  logic [PLEN-1:0] meta_paddr_q [NrSbEntries];
`else
  logic unused_paddr;
  assign unused_paddr = ^lsu_paddr_i;
`endif

  logic dispatch_en;
  assign dispatch_en = dispatch_valid_i && dispatch_ack_i && !flush_unissued_i;

  // Dispatch writes first, then LSU ports in ascending order so later writes win.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NrSbEntries; e++) begin
        meta_insn_q[e]  <= '0;
        meta_rs1_q[e]   <= '0;
        meta_rs2_q[e]   <= '0;
        meta_addr_q[e]  <= '0;
        meta_rmask_q[e] <= '0;
        meta_wmask_q[e] <= '0;
        meta_wdata_q[e] <= '0;
`ifdef RVFI_TRACK_PADDR_EN
        meta_paddr_q[e] <= '0;
`endif
      end
    end else begin
      if (dispatch_en) begin
        meta_insn_q[issue_ptr_i]  <= slot_instr_q;
        meta_rs1_q[issue_ptr_i]   <= rs1_rdata_i;
        meta_rs2_q[issue_ptr_i]   <= rs2_rdata_i;
        meta_addr_q[issue_ptr_i]  <= '0;
        meta_rmask_q[issue_ptr_i] <= '0;
        meta_wmask_q[issue_ptr_i] <= '0;
        meta_wdata_q[issue_ptr_i] <= '0;
`ifdef RVFI_TRACK_PADDR_EN
        meta_paddr_q[issue_ptr_i] <= '0;
`endif
      end
      for (int p = 0; p < NrLsuPorts; p++) begin
        if (lsu_valid_i[p] && (|lsu_be_i[p*BeW +: BeW])) begin
          meta_addr_q[lsu_trans_id_i[p*IdW +: IdW]] <= lsu_vaddr_i[p*VLEN +: VLEN];
`ifdef RVFI_TRACK_PADDR_EN
          meta_paddr_q[lsu_trans_id_i[p*IdW +: IdW]] <= lsu_paddr_i[p*PLEN +: PLEN];
`endif
          if (lsu_is_store_i[p]) begin
            meta_wmask_q[lsu_trans_id_i[p*IdW +: IdW]] <= lsu_be_i[p*BeW +: BeW];
            meta_wdata_q[lsu_trans_id_i[p*IdW +: IdW]] <= lsu_wdata_i[p*XLEN +: XLEN];
          end else begin
            meta_rmask_q[lsu_trans_id_i[p*IdW +: IdW]] <= lsu_be_i[p*BeW +: BeW];
          end
        end
      end
    end
  end

  // ---------------- commit record formation ----------------
  logic [63:0]     order_q, order_d;
  rec_t            commit_rec [NrCommitPorts];
  logic [PopW-1:0] push_cnt;

  // Build one record per commit port from registered metadata and count valid ports.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      commit_rec[i].order = order_q + 64'(i);
      commit_rec[i].insn  = meta_insn_q[commit_ptr_i[i*IdW +: IdW]];
      commit_rec[i].pc    = commit_pc_i[i*XLEN +: XLEN];
      commit_rec[i].trap  = commit_trap_i[i];
      commit_rec[i].cause = commit_cause_i;
      commit_rec[i].rs1   = meta_rs1_q[commit_ptr_i[i*IdW +: IdW]];
      commit_rec[i].rs2   = meta_rs2_q[commit_ptr_i[i*IdW +: IdW]];
      commit_rec[i].rd    = commit_rd_wdata_i[i*XLEN +: XLEN];
      commit_rec[i].addr  = meta_addr_q[commit_ptr_i[i*IdW +: IdW]];
`ifdef RVFI_TRACK_PADDR_EN
      commit_rec[i].paddr = meta_paddr_q[commit_ptr_i[i*IdW +: IdW]];
`else
      commit_rec[i].paddr = '0;
`endif
      commit_rec[i].rmask = meta_rmask_q[commit_ptr_i[i*IdW +: IdW]];
      commit_rec[i].wmask = meta_wmask_q[commit_ptr_i[i*IdW +: IdW]];
      commit_rec[i].wdata = meta_wdata_q[commit_ptr_i[i*IdW +: IdW]];
      push_cnt = push_cnt + PopW'(commit_valid_i[i]);
    end
  end

  // ---------------- retire FIFO ----------------
  rec_t            fifo_mem_q [FifoDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d, free_slots;
  logic            overflow_q, overflow_d;
  logic            pop, push_ok, push_en;

  // Group admission against post-pop occupancy; a group that does not fit is dropped whole.
  always_comb begin
    pop        = (cnt_q != '0) && rec_ready_i;
    free_slots = CntW'(FifoDepth) - (cnt_q - CntW'(pop));
    push_ok    = CntW'(push_cnt) <= free_slots;
    push_en    = push_ok && (push_cnt != '0);
    rd_ptr_d   = pop ? ptr_add(rd_ptr_q, 1) : rd_ptr_q;
    wr_ptr_d   = push_en ? ptr_add(wr_ptr_q, 32'(push_cnt)) : wr_ptr_q;
    cnt_d      = cnt_q - CntW'(pop) + (push_en ? CntW'(push_cnt) : '0);
    overflow_d = overflow_q | !push_ok;
    order_d    = order_q + 64'(push_cnt);
  end

  // FIFO bookkeeping, sticky overflow and retirement order counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      order_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      order_q    <= order_d;
    end
  end

  // FIFO storage; valid commit ports are contiguous, so port i lands at wr_ptr + i.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int i = 0; i < NrCommitPorts; i++) begin
        if (commit_valid_i[i]) fifo_mem_q[ptr_add(wr_ptr_q, i)] <= commit_rec[i];
      end
    end
  end

  rec_t head;
  assign rec_valid_o = (cnt_q != '0);
  // Head record is forced to zero when the FIFO is empty so reset leaves outputs at 0.
  always_comb begin
    head = '0;
    if (rec_valid_o) head = fifo_mem_q[rd_ptr_q];
  end

  assign rec_order_o     = head.order;
  assign rec_insn_o      = head.insn;
  assign rec_pc_o        = head.pc;
  assign rec_trap_o      = head.trap;
  assign rec_cause_o     = head.cause;
  assign rec_rs1_rdata_o = head.rs1;
  assign rec_rs2_rdata_o = head.rs2;
  assign rec_rd_wdata_o  = head.rd;
  assign rec_mem_addr_o  = head.addr;
  assign rec_mem_paddr_o = head.paddr;
  assign rec_mem_rmask_o = head.rmask;
  assign rec_mem_wmask_o = head.wmask;
  assign rec_mem_wdata_o = head.wdata;
  assign overflow_o      = overflow_q;

endmodule
